// File: rtl/ifu_burst_prefetch_if.sv
// ifu_burst_prefetch_if: redirect, IDU delivery and AXI4 read channels of the burst fetch unit
interface ifu_burst_prefetch_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic [DATA_W-1:0] inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_err;
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [3:0]        arid;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic [3:0]        rid;
  modport master (
    input  redirect_valid, redirect_pc, inst_ready, arready, rvalid, rdata, rresp, rlast, rid,
    output inst_valid, inst, inst_pc, inst_err, arvalid, araddr, arid, arlen, arsize, arburst, rready
  );
  modport slave (
    output redirect_valid, redirect_pc, inst_ready, arready, rvalid, rdata, rresp, rlast, rid,
    input  inst_valid, inst, inst_pc, inst_err, arvalid, araddr, arid, arlen, arsize, arburst, rready
  );
endinterface

// File: rtl/ifu_burst_prefetch.sv
// ifu_burst_prefetch: AXI4 INCR burst instruction fetch into a prefetch FIFO with redirect flush
module ifu_burst_prefetch #(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                BURST_LEN  = 4,
  parameter int                FIFO_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_PC   = 32'h8000_0000,
  parameter logic [3:0]        AXI_ID     = 4'd0
) (
  input logic clk,
  input logic rst,
  ifu_burst_prefetch_if.master bus
);
  localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, AR, R, DRAIN} state_t;
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] pc;
    logic              err;
  } entry_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fpc_q, fpc_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [7:0]        arlen_q, arlen_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic [ADDR_W-1:0] beat_pc_q, beat_pc_d;
  logic              kill_q, kill_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  entry_t            mem_q [FIFO_DEPTH];
  entry_t            mem_d [FIFO_DEPTH];

  logic          redir, ar_hs, r_hs, push, pop, drop;
  logic [CW-1:0] off, beats, free;
  logic          unused_ok;

  assign unused_ok = ^{bus.rid, bus.redirect_pc[1:0]};

  // next-state logic: burst sizing, AR/R sequencing, redirect handling and FIFO bookkeeping
  always_comb begin
    redir     = bus.redirect_valid;
    ar_hs     = arvalid_q & bus.arready;
    r_hs      = rready_q & bus.rvalid;
    push      = state_q == R && r_hs && !redir;
    pop       = count_q != '0 && bus.inst_ready && !redir;
    drop      = kill_q | redir;
    off       = CW'((fpc_q >> 2) & ADDR_W'(BURST_LEN - 1));
    beats     = CW'(BURST_LEN) - off;
    free      = CW'(FIFO_DEPTH) - count_q;
    state_d   = state_q;
    fpc_d     = fpc_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    beat_pc_d = push ? beat_pc_q + ADDR_W'(4) : beat_pc_q;
    kill_d    = kill_q;
    if (state_q == IDLE && !redir && free >= beats) begin
      state_d   = AR;
      arvalid_d = 1'b1;
      araddr_d  = fpc_q;
      arlen_d   = 8'(beats - CW'(1));
    end
    if (state_q == AR && ar_hs) begin
      state_d   = drop ? DRAIN : R;
      arvalid_d = 1'b0;
      rready_d  = 1'b1;
      beat_pc_d = araddr_q;
      kill_d    = 1'b0;
      fpc_d     = drop ? fpc_q : fpc_q + ((ADDR_W'(arlen_q) + ADDR_W'(1)) << 2);
    end else if (state_q == AR && redir) begin
      kill_d = 1'b1;
    end
    if ((state_q == R || state_q == DRAIN) && r_hs && bus.rlast) begin
      state_d  = IDLE;
      rready_d = 1'b0;
    end else if (state_q == R && redir) begin
      state_d = DRAIN;
    end
    if (redir) fpc_d = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
    wr_ptr_d = redir ? '0 : push ? (wr_ptr_q == PW'(FIFO_DEPTH - 1) ? '0 : wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d = redir ? '0 : pop ? (rd_ptr_q == PW'(FIFO_DEPTH - 1) ? '0 : rd_ptr_q + PW'(1)) : rd_ptr_q;
    count_d  = redir ? '0 : count_q + CW'(push) - CW'(pop);
    mem_d    = mem_q;
    if (push) mem_d[wr_ptr_q] = '{data: bus.rdata, pc: beat_pc_q, err: bus.rresp != 2'b00};
  end

  // control state and registered AXI/FIFO outputs; reset abandons any burst in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      fpc_q     <= RESET_PC;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      beat_pc_q <= '0;
      kill_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      fpc_q     <= fpc_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      beat_pc_q <= beat_pc_d;
      kill_q    <= kill_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // prefetch storage; validity is tracked by count, so no reset is needed
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.inst_valid = count_q != '0;
  assign bus.inst       = mem_q[rd_ptr_q].data;
  assign bus.inst_pc    = mem_q[rd_ptr_q].pc;
  assign bus.inst_err   = mem_q[rd_ptr_q].err;
  assign bus.arvalid    = arvalid_q;
  assign bus.araddr     = araddr_q;
  assign bus.arid       = AXI_ID;
  assign bus.arlen      = arlen_q;
  assign bus.arsize     = 3'b010;
  assign bus.arburst    = 2'b01;
  assign bus.rready     = rready_q;
endmodule
